// File: rtl/viterbi_ctrl_pkg.sv
// Shared types and defaults for the Viterbi frame controller.
package viterbi_ctrl_pkg;

  localparam int DEF_SIZE_DATA_IN  = 16;
  localparam int DEF_SIZE_DATA_OUT = 8;
  localparam int DEF_TIMEOUT_CYC   = 64;

  // Frame lifecycle: wait for a request, kick the PISO, wait for both
  // serialiser/deserialiser completions (or timeout), hand back the result.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Identifies one of the two requesters.
  typedef logic req_id_t;

  // One-hot accept vector for a granted requester.
  function automatic logic [1:0] id_onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the requester with
// priority; it moves to the other requester when a frame is retired.
module rr_arb2
  import viterbi_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  req_id_t    upd_id,
  output req_id_t    grant,
  output logic       any
);

  req_id_t ptr;

  // Priority pointer: after serving a requester, favour the other one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (upd) begin
      ptr <= ~upd_id;
    end
  end

  // Grant the pointed-to requester if it asks, otherwise the other one.
  always_comb begin
    grant = req[ptr] ? ptr : ~ptr;
    any   = |req;
  end

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame controller: arbitrates two requesters, launches one coded word to
// the PISO, waits for PISO and SIPO completion (bounded by a timeout) and
// returns the decoded byte on a response channel.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. o_req_ready is only offered in IDLE and never depends on state
// outside IDLE; o_rsp_valid, once raised, holds with stable id/data/err until
// the edge where i_rsp_ready is seen high.
module viterbi_frame_ctrl
  import viterbi_ctrl_pkg::*;
#(
  parameter int SIZE_DATA_IN  = DEF_SIZE_DATA_IN,
  parameter int SIZE_DATA_OUT = DEF_SIZE_DATA_OUT,
  parameter int TIMEOUT_CYC   = DEF_TIMEOUT_CYC
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [1:0]                   i_req_valid,
  input  logic [1:0][SIZE_DATA_IN-1:0] i_req_data,
  output logic [1:0]                   o_req_ready,
  output logic                         o_start,
  output logic [SIZE_DATA_IN-1:0]      o_data,
  input  logic                         i_done_piso,
  input  logic                         i_done_sipo,
  input  logic [SIZE_DATA_OUT-1:0]     i_data_sipo,
  output logic                         o_rsp_valid,
  output logic                         o_rsp_id,
  output logic [SIZE_DATA_OUT-1:0]     o_rsp_data,
  output logic                         o_rsp_err,
  input  logic                         i_rsp_ready,
  output logic                         o_busy
);

  localparam int CW = $clog2(TIMEOUT_CYC) + 1;

  state_t                   state;
  state_t                   state_nxt;
  req_id_t                  grant;
  req_id_t                  id_q;
  logic                     any_valid;
  logic                     req_hs;
  logic                     rsp_hs;
  logic                     piso_seen;
  logic                     sipo_seen;
  logic                     all_done;
  logic                     timeout;
  logic [CW-1:0]            cnt;
  logic [CW-1:0]            cnt_inc;
  logic [SIZE_DATA_IN-1:0]  data_q;
  logic [SIZE_DATA_OUT-1:0] rsp_data_q;
  logic                     rsp_err_q;

  rr_arb2 u_arb (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .req    (i_req_valid),
    .upd    (rsp_hs),
    .upd_id (id_q),
    .grant  (grant),
    .any    (any_valid)
  );

  // Handshake strobes and RUN-phase completion/timeout decisions. A done
  // pulse arriving this cycle counts immediately, so it beats a timeout
  // raised in the same cycle.
  always_comb begin
    req_hs   = (state == ST_IDLE) && any_valid;
    rsp_hs   = (state == ST_RESP) && i_rsp_ready;
    all_done = (piso_seen | i_done_piso) & (sipo_seen | i_done_sipo);
    cnt_inc  = (cnt == '1) ? cnt : cnt + CW'(1);
    timeout  = (cnt_inc >= CW'(TIMEOUT_CYC - 1));
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (req_hs) state_nxt = ST_START;
      ST_START: state_nxt = ST_RUN;
      ST_RUN:   if (all_done || timeout) state_nxt = ST_RESP;
      ST_RESP:  if (rsp_hs) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Frame datapath: latched request, completion flags, timeout counter and
  // response fields. Done pulses only matter while in RUN.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      data_q     <= '0;
      id_q       <= 1'b0;
      piso_seen  <= 1'b0;
      sipo_seen  <= 1'b0;
      cnt        <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_hs) begin
            data_q <= i_req_data[grant];
            id_q   <= grant;
          end
        end
        ST_START: begin
          cnt <= '0;
        end
        ST_RUN: begin
          cnt <= cnt_inc;
          if (i_done_piso) piso_seen <= 1'b1;
          if (i_done_sipo) begin
            sipo_seen  <= 1'b1;
            rsp_data_q <= i_data_sipo;
          end
          if (all_done) begin
            rsp_err_q <= 1'b0;
          end else if (timeout) begin
            rsp_err_q  <= 1'b1;
            rsp_data_q <= '0;
          end
        end
        ST_RESP: begin
          if (rsp_hs) begin
            piso_seen <= 1'b0;
            sipo_seen <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    o_req_ready = (state == ST_IDLE && any_valid) ? id_onehot(grant) : 2'b00;
    o_start     = (state == ST_START);
    o_data      = data_q;
    o_rsp_valid = (state == ST_RESP);
    o_rsp_id    = id_q;
    o_rsp_data  = rsp_data_q;
    o_rsp_err   = rsp_err_q;
    o_busy      = (state != ST_IDLE);
  end

endmodule

// File: doc/viterbi_frame_ctrl.md
VITERBI_FRAME_CTRL -- requirements
Module: viterbi_frame_ctrl

Interface
REQ-001 Parameters SHALL be: SIZE_DATA_IN, default 16, width of the coded word sent to the PISO; SIZE_DATA_OUT, default 8, width of the decoded byte from the SIPO; TIMEOUT_CYC, default 64, maximum cycles per frame from start to done.
REQ-002 i_clk  in  1  single clock; all logic rising-edge.
REQ-003 i_rst_n  in  1  reset, synchronous, active-low.
REQ-004 i_req_valid  in  2  per-requester frame valid.
REQ-005 i_req_data  in  2 x SIZE_DATA_IN  per-requester coded word (packed [1:0]).
REQ-006 o_req_ready  out  2  per-requester accept, one-hot or zero.
REQ-007 o_start  out  1  one-cycle start pulse to the PISO.
REQ-008 o_data  out  SIZE_DATA_IN  word to the PISO, stable from o_start until the frame ends.
REQ-009 i_done_piso  in  1  PISO finished serialising (pulse).
REQ-010 i_done_sipo  in  1  SIPO byte complete (pulse).
REQ-011 i_data_sipo  in  SIZE_DATA_OUT  decoded byte, valid with i_done_sipo.
REQ-012 o_rsp_valid / o_rsp_id (1) / o_rsp_data (SIZE_DATA_OUT) / o_rsp_err (1)  out  response channel.
REQ-013 i_rsp_ready  in  1  response consumer accept.
REQ-014 o_busy  out  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, START, RUN, RESP.
REQ-016 IDLE: grant = round-robin pointer if that requester is valid, else the other requester; o_req_ready[grant] = 1 combinationally when any valid is high; on handshake, latch data and id and go to START.
REQ-017 START: o_start = 1 for exactly one cycle; then go to RUN. Latency from request handshake to o_start SHALL be 1 cycle.
REQ-018 RUN: sticky flags piso_seen and sipo_seen set on i_done_piso / i_done_sipo; i_data_sipo captured in the i_done_sipo cycle; go to RESP with err = 0 in the cycle after both flags are set (including both in the same cycle).
REQ-019 Timeout counter SHALL clear in START, increment every RUN cycle, saturate; reaching TIMEOUT_CYC-1 without both flags SHALL go to RESP with err = 1 and data = 0.
REQ-020 A done and a timeout in the same cycle: the done SHALL win (err = 0).
REQ-021 RESP: o_rsp_valid held with stable id/data/err until i_rsp_ready; on handshake, pointer = ~served id, flags cleared, go to IDLE.
REQ-022 Done pulses in IDLE, START or RESP SHALL be ignored.
REQ-023 o_req_ready SHALL be 0 outside IDLE; no new frame SHALL start before the current response is accepted.
REQ-024 Counter width SHALL be $clog2(TIMEOUT_CYC)+1 bits; no wrap.

Reset
REQ-025 With i_rst_n low at a clock edge: state = IDLE, pointer = 0, flags/counter = 0, o_start = 0, o_data = 0, o_rsp_valid = 0, o_rsp_data = 0, o_rsp_err = 0, o_rsp_id = 0, o_busy = 0.
REQ-026 Reset mid-frame SHALL abort the frame with no response; a done pulse in the reset cycle SHALL be dropped.

Structure
REQ-027 Package viterbi_ctrl_pkg SHALL hold the state enum, default SIZE_DATA_IN/SIZE_DATA_OUT/TIMEOUT_CYC constants, and the requester-id type.
REQ-028 One sub-module, rr_arb2 (2-way round-robin grant with pointer update on a strobe), SHALL be used.

Verification
REQ-029 Req0 = 16'hA5C3, PISO done at +8, SIPO done at +12 with 8'h5A -> o_start one cycle after handshake; rsp id 0, data 8'h5A, err 0.
REQ-030 Both requesters valid every cycle, consumer always ready -> grants alternate 0,1,0,1 over four frames.
REQ-031 No done pulses -> RESP entered exactly TIMEOUT_CYC cycles after o_start, err 1, data 8'h00.
REQ-032 Both done pulses in the same cycle, and a done coinciding with the timeout cycle -> err 0, data captured.
REQ-033 i_rsp_ready low for 5 cycles -> rsp fields stable, o_req_ready = 0 throughout; a stray done in RESP is ignored.
REQ-034 Reset asserted in RUN -> next cycle IDLE, all outputs 0, and the subsequent frame is granted to requester 0.
